// File: rtl/gpr_wr_arb.sv
// ============================================================================
// gpr_wr_arb: write-port arbiter for the GPR file (load / ALU / mul-div),
// fixed priority 0>1>2 with a per-requester starvation guard.
// Optional macro GPR_ARB_CLEAR_EN: post-reset zero-fill of every register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpr_wr_arb #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req_valid,
    output logic [2:0]    req_ready,
    input  logic [AW-1:0] req_addr_0,
    input  logic [AW-1:0] req_addr_1,
    input  logic [AW-1:0] req_addr_2,
    input  logic [DW-1:0] req_data_0,
    input  logic [DW-1:0] req_data_1,
    input  logic [DW-1:0] req_data_2,
    output logic          gpr_we_,
    output logic [AW-1:0] gpr_wr_addr,
    output logic [DW-1:0] gpr_wr_data,
    output logic [1:0]    grant_id,
    output logic          busy
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic          run;
    logic          clearing;
    logic [AW-1:0] clr_addr;
    logic [2:0]    starved;
    logic [2:0]    cand;
    logic [2:0]    grant;
    logic [1:0]    grant_idx;
    logic [3:0]    wait_cnt [3];

`ifdef GPR_ARB_CLEAR_EN
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam logic [AW-1:0] CLR_LAST = '1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        run      = (state == S_RUN);
        clearing = (state == S_CLEAR);
        busy     = (state == S_CLEAR);
        clr_addr = clr_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset)         clr_cnt <= '0;
        else if (clearing) clr_cnt <= clr_cnt + 1'b1;
    end
`else
    assign run      = 1'b1;
    assign clearing = 1'b0;
    assign busy     = 1'b0;
    assign clr_addr = '0;
`endif

    // Starved requesters, if any valid, form the candidate set; else all valid ones.
    always_comb begin
        for (int i = 0; i < 3; i++) starved[i] = (wait_cnt[i] == SMAX);
        cand  = ((req_valid & starved) != 3'b000) ? (req_valid & starved) : req_valid;
        grant = 3'b000;
        if (!reset && run) begin
            if (cand[0])      grant = 3'b001;
            else if (cand[1]) grant = 3'b010;
            else if (cand[2]) grant = 3'b100;
        end
        grant_idx = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
        req_ready = grant;
    end

    for (genvar i = 0; i < 3; i++) begin : g_wait
        always_ff @(posedge clk) begin
            if (reset)
                wait_cnt[i] <= '0;
            else if (run) begin
                if (!req_valid[i] || grant[i]) wait_cnt[i] <= '0;
                else if (wait_cnt[i] != SMAX)  wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_we_     <= 1'b1;
            gpr_wr_addr <= '0;
            gpr_wr_data <= '0;
            grant_id    <= 2'd0;
        end else if (clearing) begin
            gpr_we_     <= 1'b0;
            gpr_wr_addr <= clr_addr;
            gpr_wr_data <= '0;
            grant_id    <= 2'd3;
        end else if (grant != 3'b000) begin
            gpr_we_  <= 1'b0;
            grant_id <= grant_idx;
            case (grant_idx)
                2'd0:    begin gpr_wr_addr <= req_addr_0; gpr_wr_data <= req_data_0; end
                2'd1:    begin gpr_wr_addr <= req_addr_1; gpr_wr_data <= req_data_1; end
                default: begin gpr_wr_addr <= req_addr_2; gpr_wr_data <= req_data_2; end
            endcase
        end else begin
            gpr_we_ <= 1'b1;
        end
    end

endmodule

`default_nettype wire
